// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART with an RX FIFO, status/control registers
// and a level interrupt raised while received data waits and rx_ie is set.
module uart_mmio #(
    parameter int CLK_DIV  = 434,
    parameter int RX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic        re,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    input  logic        rx,
    output logic        tx,
    output logic        irq
);

    localparam int           AW      = $clog2(RX_DEPTH);
    localparam logic [15:0]  DIV_M1  = 16'(CLK_DIV - 1);
    localparam logic [15:0]  HALF_M1 = 16'(CLK_DIV / 2 - 1);
    localparam logic [AW:0]  DEPTH_C = (AW + 1)'(RX_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Reset release synchronizer; the FSMs may only leave IDLE once it is through.
    logic [1:0] rst_sync_q;
    logic       run;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign run = rst_sync_q[1];

    // Bus access edge detection: only the first cycle of a held strobe acts.
    logic rd_acc, wr_acc, rd_prev_q, wr_prev_q, rd_first, wr_first;
    assign rd_acc   = cs & re;
    assign wr_acc   = cs & we;
    assign rd_first = rd_acc & ~rd_prev_q;
    assign wr_first = wr_acc & ~wr_prev_q;

    // Remember last cycle's strobes; they fall naturally when cs drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_prev_q <= 1'b0;
            wr_prev_q <= 1'b0;
        end else begin
            rd_prev_q <= rd_acc;
            wr_prev_q <= wr_acc;
        end
    end

    // RX FIFO state and status flags.
    logic [7:0]    fifo_mem [RX_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          rx_avail, rx_full, pop, rx_push, push_ok, ovr_set, fe_set;
    logic          overrun_q, overrun_d, frame_err_q, frame_err_d, rx_ie_q, irq_q;
    logic          w1c;
    logic          tx_busy;
    logic [7:0]    rx_shift_q;

    assign rx_avail = (cnt_q != '0);
    assign rx_full  = (cnt_q == DEPTH_C);
    assign pop      = rd_first & (addr == 2'd0) & rx_avail;
    assign push_ok  = rx_push & (~rx_full | pop);
    assign ovr_set  = rx_push & rx_full & ~pop;
    assign w1c      = wr_first & (addr == 2'd1);

    // Next-state for the FIFO count and sticky flags (a new event beats W1C).
    always_comb begin
        cnt_d = cnt_q;
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        overrun_d   = ovr_set | (overrun_q & ~(w1c & wdata[2]));
        frame_err_d = fe_set  | (frame_err_q & ~(w1c & wdata[4]));
    end

    // FIFO storage has no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= rx_shift_q;
    end

    // FIFO pointers, count, flags, interrupt enable and registered irq.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_ie_q     <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q       <= cnt_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            if (wr_first && addr == 2'd2) rx_ie_q <= wdata[0];
            irq_q       <= rx_ie_q & rx_avail;
        end
    end
    assign irq = irq_q;

    // Read mux; after the first cycle the captured value is replayed so a
    // held read does not show the post-pop head.
    logic [15:0] rd_now, rd_hold_q;

    // Select the register image for the current address.
    always_comb begin
        rd_now = 16'h0000;
        case (addr)
            2'd0:    rd_now = rx_avail ? {8'h00, fifo_mem[rd_ptr_q]} : 16'h0000;
            2'd1:    rd_now = {11'b0, frame_err_q, rx_full, overrun_q, tx_busy, rx_avail};
            2'd2:    rd_now = {15'b0, rx_ie_q};
            default: rd_now = 16'h0000;
        endcase
    end

    // Capture the read value on the first cycle of an access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        rd_hold_q <= 16'h0000;
        else if (rd_first) rd_hold_q <= rd_now;
    end
    assign rdata = rd_acc ? (rd_first ? rd_now : rd_hold_q) : 16'h0000;

    // Transmitter.
    tx_state_t   tx_state_q;
    logic [15:0] tx_cnt_q;
    logic [2:0]  tx_bit_q;
    logic [7:0]  tx_shift_q;
    logic        tx_q;

    assign tx_busy = (tx_state_q != TX_IDLE);
    assign tx      = tx_q;

    // TX FSM: start bit, 8 data bits LSB first, stop bit, each CLK_DIV cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    tx_q <= 1'b1;
                    if (run && wr_first && addr == 2'd0) begin
                        tx_state_q <= TX_START;
                        tx_shift_q <= wdata[7:0];
                        tx_cnt_q   <= '0;
                        tx_q       <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == DIV_M1) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_q       <= tx_shift_q[0];
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == DIV_M1) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 3'd7) begin
                            tx_q       <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            tx_bit_q   <= tx_bit_q + 3'd1;
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                            tx_q       <= tx_shift_q[1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                default: begin
                    if (tx_cnt_q == DIV_M1) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_state_q <= TX_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
            endcase
        end
    end

    // Receiver.
    rx_state_t   rx_state_q;
    logic [15:0] rx_cnt_q;
    logic [2:0]  rx_bit_q;
    logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_centre;

    assign rx_centre = (rx_cnt_q == DIV_M1);
    assign rx_push   = (rx_state_q == RX_STOP) & rx_centre & rx_s2_q;
    assign fe_set    = (rx_state_q == RX_STOP) & rx_centre & ~rx_s2_q;

    // Two-flop synchronizer on rx plus a delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    // RX FSM: half-bit start qualification, then samples at each bit centre.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    rx_cnt_q <= '0;
                    if (run && rx_prev_q && !rx_s2_q) rx_state_q <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_M1) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_centre) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
                        else                  rx_bit_q   <= rx_bit_q + 3'd1;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                default: begin
                    if (rx_centre) begin
                        rx_cnt_q   <= '0;
                        rx_bit_q   <= '0;
                        rx_state_q <= RX_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
            endcase
        end
    end

    // Upper write-data bits carry nothing for this peripheral.
    logic unused_wdata;
    assign unused_wdata = ^wdata[15:8];

endmodule
